// File: rtl/ddr3_app_bram.sv
// ddr3_app_bram: MIG-style app interface responder backed by an on-chip array.
// Ports: ddr_clk/ddr_rst (sync, active-high); app_* command, write-data and
// read-data channels; phy_init_done after INIT_CYCLES.
// Optional: define DDR3_APP_BRAM_BACKPRESSURE_EN for LFSR-driven ready stalls.
module ddr3_app_bram #(
    parameter int ADDR_WIDTH     = 27,
    parameter int APP_DATA_WIDTH = 256,
    parameter int APP_MASK_WIDTH = APP_DATA_WIDTH / 8,
    parameter int MEM_AW         = 8,
    parameter int INIT_CYCLES    = 16,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      ddr_clk,
    input  logic                      ddr_rst,
    input  logic [ADDR_WIDTH-1:0]     app_addr,
    input  logic [2:0]                app_cmd,
    input  logic                      app_en,
    input  logic                      app_hi_pri,
    input  logic                      app_sz,
    input  logic [APP_DATA_WIDTH-1:0] app_wdf_data,
    input  logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
    input  logic                      app_wdf_wren,
    input  logic                      app_wdf_end,
    output logic                      app_rdy,
    output logic                      app_wdf_rdy,
    output logic [APP_DATA_WIDTH-1:0] app_rd_data,
    output logic                      app_rd_data_valid,
    output logic                      app_rd_data_end,
    output logic                      phy_init_done
);

    localparam int DEPTH = 1 << MEM_AW;
    localparam int ICW   = $clog2(INIT_CYCLES + 1);
    localparam int LCW   = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WR_WAIT,
        RD_LAT
    } state_t;

    state_t                    state;
    logic [ICW-1:0]            init_cnt;
    logic [LCW-1:0]            lat_cnt;
    logic [MEM_AW-1:0]         addr_q;

    logic [APP_DATA_WIDTH-1:0] mem [DEPTH];

    logic [APP_DATA_WIDTH-1:0] fifo_data [4];
    logic [APP_MASK_WIDTH-1:0] fifo_mask [4];
    logic [1:0]                wr_ptr;
    logic [1:0]                rd_ptr;
    logic [2:0]                fifo_cnt;

    logic                      cmd_hold;
    logic                      wdf_hold;
    logic                      cmd_acc;
    logic                      push;
    logic                      pop;
    logic                      fifo_full;
    logic                      unused_ok;

    // Sideband inputs with no effect on this single-beat model.
    assign unused_ok = ^{app_hi_pri, app_sz, app_wdf_end, app_addr};

`ifdef DDR3_APP_BRAM_BACKPRESSURE_EN
    logic [15:0] lfsr;

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign cmd_hold = (lfsr[1:0] == 2'b00);
    assign wdf_hold = (lfsr[3:2] == 2'b00);
`else
    assign cmd_hold = 1'b0;
    assign wdf_hold = 1'b0;
`endif

    assign fifo_full   = (fifo_cnt == 3'd4);
    assign app_rdy     = (state == IDLE) && !cmd_hold;
    assign app_wdf_rdy = !fifo_full && phy_init_done && !wdf_hold;
    assign cmd_acc     = app_en && app_rdy;
    assign pop         = (state == WR_WAIT) && (fifo_cnt != 3'd0);

    // A pop frees the slot being written, so a full FIFO still takes a
    // beat in the same cycle it drains one.
    assign push = app_wdf_wren && phy_init_done && !wdf_hold &&
                  (!fifo_full || pop);

    always_ff @(posedge ddr_clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= app_wdf_data;
            fifo_mask[wr_ptr] <= app_wdf_mask;
        end
    end

    // Array is never reset; a reset cycle suppresses a pending write.
    always_ff @(posedge ddr_clk) begin
        if (!ddr_rst && pop) begin
            for (int i = 0; i < APP_MASK_WIDTH; i++) begin
                if (!fifo_mask[rd_ptr][i]) begin
                    mem[addr_q][i*8 +: 8] <= fifo_data[rd_ptr][i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            state             <= INIT;
            init_cnt          <= '0;
            lat_cnt           <= '0;
            addr_q            <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            fifo_cnt          <= '0;
            phy_init_done     <= 1'b0;
            app_rd_data_valid <= 1'b0;
            app_rd_data_end   <= 1'b0;
            app_rd_data       <= '0;
        end else begin
            app_rd_data_valid <= 1'b0;
            app_rd_data_end   <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 3'd1;
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - 3'd1;
            end

            case (state)
                INIT: begin
                    if (init_cnt == ICW'(INIT_CYCLES - 1)) begin
                        state         <= IDLE;
                        phy_init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (cmd_acc) begin
                        case (app_cmd)
                            3'b000: begin
                                addr_q <= app_addr[MEM_AW+1:2];
                                state  <= WR_WAIT;
                            end
                            3'b001: begin
                                addr_q  <= app_addr[MEM_AW+1:2];
                                lat_cnt <= '0;
                                state   <= RD_LAT;
                            end
                            default: ;
                        endcase
                    end
                end
                WR_WAIT: begin
                    if (pop) begin
                        state <= IDLE;
                    end
                end
                RD_LAT: begin
                    if (lat_cnt == LCW'(READ_LATENCY - 1)) begin
                        app_rd_data       <= mem[addr_q];
                        app_rd_data_valid <= 1'b1;
                        app_rd_data_end   <= 1'b1;
                        state             <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_app_bram.sv
// tb_ddr3_app_bram: directed stimulus with a read-data scoreboard.
// Reads push expected data and due cycle; a negedge monitor checks them.
module tb_ddr3_app_bram;

    localparam int AW = 27;
    localparam int DW = 256;
    localparam int MW = DW / 8;

    logic          ddr_clk = 1'b0;
    logic          ddr_rst = 1'b1;
    logic [AW-1:0] app_addr = '0;
    logic [2:0]    app_cmd = '0;
    logic          app_en = 1'b0;
    logic          app_hi_pri = 1'b0;
    logic          app_sz = 1'b0;
    logic [DW-1:0] app_wdf_data = '0;
    logic [MW-1:0] app_wdf_mask = '0;
    logic          app_wdf_wren = 1'b0;
    logic          app_wdf_end = 1'b0;
    logic          app_rdy;
    logic          app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid;
    logic          app_rd_data_end;
    logic          phy_init_done;

    ddr3_app_bram dut (
        .ddr_clk          (ddr_clk),
        .ddr_rst          (ddr_rst),
        .app_addr         (app_addr),
        .app_cmd          (app_cmd),
        .app_en           (app_en),
        .app_hi_pri       (app_hi_pri),
        .app_sz           (app_sz),
        .app_wdf_data     (app_wdf_data),
        .app_wdf_mask     (app_wdf_mask),
        .app_wdf_wren     (app_wdf_wren),
        .app_wdf_end      (app_wdf_end),
        .app_rdy          (app_rdy),
        .app_wdf_rdy      (app_wdf_rdy),
        .app_rd_data      (app_rd_data),
        .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end  (app_rd_data_end),
        .phy_init_done    (phy_init_done)
    );

    always #5 ddr_clk = ~ddr_clk;

    int cyc = 0;
    always @(posedge ddr_clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails = 0;

    localparam logic [DW-1:0] PAT_A = {32{8'hAA}};
    localparam logic [DW-1:0] PAT_5 = {32{8'h55}};
    localparam logic [DW-1:0] PAT_X = {8{32'hDEADBEEF}};

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge ddr_clk) begin
        if (app_rd_data_valid) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL rd_unexpected: got valid with %h want none",
                         app_rd_data);
            end else begin
                mon_e = sb.pop_front();
                chk("rd_data", app_rd_data, mon_e.data);
                chk("rd_end", DW'(app_rd_data_end), DW'(1));
                chk("rd_latency", DW'(cyc), DW'(mon_e.due));
            end
        end
    end

    task automatic tick();
        @(posedge ddr_clk);
        #1;
    endtask

    task automatic do_init();
        bit bad;
        ddr_rst = 1'b1;
        repeat (3) tick();
        chk("rst_flags",
            DW'({phy_init_done, app_rdy, app_wdf_rdy,
                 app_rd_data_valid, app_rd_data_end}), '0);
        chk("rst_rd_data", app_rd_data, '0);
        ddr_rst = 1'b0;
        bad = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (phy_init_done || app_rdy || app_wdf_rdy) bad = 1'b1;
            tick();
        end
        chk("init_low", DW'(bad), '0);
        chk("init_done", DW'(phy_init_done), DW'(1));
        chk("rdy_after_init", DW'({app_rdy, app_wdf_rdy}), DW'(2'b11));
    endtask

    task automatic wdf(input logic [DW-1:0] d, input logic [MW-1:0] m);
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
        app_wdf_data = d;
        app_wdf_mask = m;
        tick();
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
    endtask

    task automatic cmd(input logic [2:0] c, input logic [AW-1:0] a,
                       output int acc);
        int n;
        app_en   = 1'b1;
        app_cmd  = c;
        app_addr = a;
        n = 0;
        while (!app_rdy && n < 200) begin
            tick();
            n++;
        end
        if (!app_rdy) begin
            checks++;
            fails++;
            $display("FAIL cmd_timeout: got app_rdy 0 want 1 addr %h", a);
            app_en = 1'b0;
            acc = -1;
        end else begin
            tick();
            acc = cyc;
            app_en = 1'b0;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a);
        int acc;
        cmd(3'b000, a, acc);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int acc;
        cmd(3'b001, a, acc);
        if (acc >= 0) sb.push_back('{d, acc + 4});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending reads want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] d [5];
    logic [DW-1:0] d5;
    bit            bad;
    int            acc;

    initial begin
        for (int i = 0; i < 5; i++) d[i] = {8{32'hC0DE0000 + 32'(i)}};
        d5 = {8{32'h5A5A0005}};

        do_init();

        wdf(PAT_A, '0);
        wr(27'h10);
        rd(27'h10, PAT_A);
        drain();
        repeat (3) tick();
        chk("rd_hold", app_rd_data, PAT_A);
        chk("valid_low", DW'({app_rd_data_valid, app_rd_data_end}), '0);

        wr(27'h20);
        bad = 1'b0;
        repeat (10) begin
            if (app_rdy) bad = 1'b1;
            tick();
        end
        chk("wr_wait_rdy_low", DW'(bad), '0);
        wdf(PAT_X, '0);
        rd(27'h20, PAT_X);
        drain();

        wdf(PAT_5, 32'h0000FFFF);
        wr(27'h10);
        rd(27'h10, {PAT_5[255:128], PAT_A[127:0]});
        drain();

        chk("wdf_rdy_empty", DW'(app_wdf_rdy), DW'(1));
        for (int i = 0; i < 5; i++) begin
            app_wdf_wren = 1'b1;
            app_wdf_data = d[i];
            app_wdf_mask = '0;
            tick();
            if (i == 3) chk("wdf_full", DW'(app_wdf_rdy), '0);
        end
        app_wdf_wren = 1'b0;
        wr(27'h40);
        wr(27'h44);
        wr(27'h48);
        wr(27'h4C);
        tick();
        chk("wdf_rdy_drained", DW'(app_wdf_rdy), DW'(1));
        rd(27'h40, d[0]);
        rd(27'h44, d[1]);
        rd(27'h48, d[2]);
        rd(27'h4C, d[3]);
        drain();
        wr(27'h50);
        repeat (3) tick();
        chk("fifth_dropped", DW'(app_rdy), '0);
        wdf(d5, '0);
        rd(27'h50, d5);
        drain();

        cmd(3'b001, 27'h10, acc);
        repeat (2) tick();
        do_init();
        repeat (4) tick();
        rd(27'h10, {PAT_5[255:128], PAT_A[127:0]});
        drain();

        repeat (5) tick();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
